// File: rtl/tis_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : tis_stream_arbiter_if
// Purpose  : N:1 stream bundle, with requester words in and one tagged word out.
// Revision : 1.0
// ============================================================================
interface tis_stream_arbiter_if #(
   parameter int NUM_IN = 4,
   parameter int DATA_W = 11
);
   localparam int c_SRC_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   logic [NUM_IN*DATA_W-1:0] in_data;
   logic [NUM_IN-1:0]        in_valid;
   logic [NUM_IN-1:0]        in_ready;
   logic [DATA_W-1:0]        out_data;
   logic [c_SRC_W-1:0]       out_src;
   logic                     out_valid;
   logic                     out_ready;

   // master: the producers and the consumer around the arbiter; slave: the arbiter itself
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_src, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_src, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/tis_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tis_stream_arbiter
// Purpose  : Round-robin N:1 stream arbiter with bounded bursts and a registered, source-tagged output.
// Revision : 1.0
// ============================================================================
module tis_stream_arbiter #(
   parameter int NUM_IN = 4,
   parameter int DATA_W = 11,
   parameter int BURST  = 4
) (
   input  wire logic          clk,
   input  wire logic          reset,
   tis_stream_arbiter_if.slave bus
);
   localparam int                 c_SRC_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int                 c_CNT_W     = 4;
   localparam logic [0:0]         c_S_IDLE    = 1'b0;
   localparam logic [0:0]         c_S_GRANT   = 1'b1;
   localparam logic [c_SRC_W-1:0] c_LAST_INIT = c_SRC_W'(NUM_IN - 1);
   localparam logic [c_CNT_W-1:0] c_BURST     = c_CNT_W'(BURST);

   logic [0:0]         r_state;
   logic [0:0]         w_state_nxt;
   logic [c_SRC_W-1:0] r_grant;
   logic [c_SRC_W-1:0] r_last_grant;
   logic [c_CNT_W-1:0] r_count;
   logic [DATA_W-1:0]  r_out_data;
   logic [c_SRC_W-1:0] r_out_src;
   logic               r_out_valid;

   logic               w_found;
   logic [c_SRC_W-1:0] w_pick;
   logic [c_SRC_W-1:0] w_scan_idx;
   int                 w_scan_sum;
   logic               w_slot_free;
   logic               w_grant_valid;
   logic [DATA_W-1:0]  w_grant_data;
   logic               w_accept;
   logic               w_release;
   logic [NUM_IN-1:0]  w_in_ready;

   // Scan starts just past the last released grant, so that grant ends up with the lowest priority
   always_comb begin
      w_found    = 1'b0;
      w_pick     = '0;
      w_scan_sum = 0;
      w_scan_idx = '0;
      for (int k = 1; k <= NUM_IN; k++) begin
         w_scan_sum = int'(r_last_grant) + k;
         if (w_scan_sum >= NUM_IN) begin
            w_scan_sum = w_scan_sum - NUM_IN;
         end
         w_scan_idx = c_SRC_W'(w_scan_sum);
         if (!w_found && bus.in_valid[w_scan_idx]) begin
            w_found = 1'b1;
            w_pick  = w_scan_idx;
         end
      end
   end

   assign w_slot_free   = !r_out_valid || bus.out_ready;
   assign w_grant_valid = bus.in_valid[r_grant];
   assign w_grant_data  = bus.in_data[int'(r_grant)*DATA_W +: DATA_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE: begin
            if (w_found) begin
               w_state_nxt = c_S_GRANT;
            end
         end
         c_S_GRANT: begin
            if (w_release) begin
               w_state_nxt = c_S_IDLE;
            end
         end
         default: w_state_nxt = c_S_IDLE;
      endcase
   end

   // Gated with reset so that nothing is accepted in the reset cycle itself
   always_comb begin
      w_in_ready = '0;
      w_accept   = 1'b0;
      w_release  = 1'b0;
      if ((r_state == c_S_GRANT) && !reset) begin
         w_in_ready[r_grant] = w_slot_free;
         w_accept            = w_grant_valid && w_slot_free;
         w_release           = (w_accept && ((r_count + c_CNT_W'(1)) == c_BURST)) || !w_grant_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant      <= '0;
         r_last_grant <= c_LAST_INIT;
         r_count      <= '0;
      end else if (r_state == c_S_IDLE) begin
         r_count <= '0;
         if (w_found) begin
            r_grant <= w_pick;
         end
      end else begin
         if (w_accept) begin
            r_count <= r_count + c_CNT_W'(1);
         end
         if (w_release) begin
            r_last_grant <= r_grant;
         end
      end
   end

   // A new word may replace one being drained in the same cycle, which gives full throughput
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_data  <= w_grant_data;
         r_out_src   <= r_grant;
         r_out_valid <= 1'b1;
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_data  = r_out_data;
   assign bus.out_src   = r_out_src;
   assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_tis_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tis_stream_arbiter
// Purpose  : Directed and random-soak self-checking bench for tis_stream_arbiter (BURST=4 and BURST=2 instances).
// Revision : 1.0
// ============================================================================
module tb_tis_stream_arbiter;
   localparam int c_N        = 4;
   localparam int c_DW       = 11;
   localparam int c_SW       = 2;
   localparam int c_MAX_WAIT = (c_N - 1) * (4 + 1) + 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [c_N*c_DW-1:0] tb_in_data;
   logic [c_N-1:0]      tb_in_valid;
   logic                tb_out_ready;
   logic                sel = 1'b0;

   tis_stream_arbiter_if #(.NUM_IN(c_N), .DATA_W(c_DW)) bus4 ();
   tis_stream_arbiter_if #(.NUM_IN(c_N), .DATA_W(c_DW)) bus2 ();

   assign bus4.in_data   = tb_in_data;
   assign bus4.in_valid  = tb_in_valid;
   assign bus4.out_ready = tb_out_ready;
   assign bus2.in_data   = tb_in_data;
   assign bus2.in_valid  = tb_in_valid;
   assign bus2.out_ready = tb_out_ready;

   tis_stream_arbiter #(.NUM_IN(c_N), .DATA_W(c_DW), .BURST(4)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

   tis_stream_arbiter #(.NUM_IN(c_N), .DATA_W(c_DW), .BURST(2)) u_dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   logic [c_N-1:0]  ob_in_ready;
   logic [c_DW-1:0] ob_out_data;
   logic [c_SW-1:0] ob_out_src;
   logic            ob_out_valid;
   assign ob_in_ready  = sel ? bus2.in_ready  : bus4.in_ready;
   assign ob_out_data  = sel ? bus2.out_data  : bus4.out_data;
   assign ob_out_src   = sel ? bus2.out_src   : bus4.out_src;
   assign ob_out_valid = sel ? bus2.out_valid : bus4.out_valid;

   logic [c_DW-1:0] src_q [c_N][$];
   logic [c_DW-1:0] exp_q [c_N][$];
   int              tr_src [$];
   int              tr_cyc [$];
   logic [c_DW-1:0] tr_data [$];

   logic [c_N-1:0] gate      = '1;
   logic [c_N-1:0] acc_pend  = '0;
   logic           gate_rand = 1'b0;
   logic           rdy_rand  = 1'b0;
   logic           rdy_force = 1'b1;
   logic           rdy_roll  = 1'b1;
   logic           wait_en   = 1'b0;
   int             wait_cnt [c_N];
   int             max_wait  = 0;
   int             cyc       = 0;
   int             n_checks  = 0;
   int             n_errors  = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < c_N; i++) begin
         tb_in_valid[i] = (src_q[i].size() > 0) && gate[i];
         tb_in_data[i*c_DW +: c_DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      end
      tb_out_ready = rdy_rand ? rdy_roll : rdy_force;
   endtask

   function automatic logic all_empty();
      logic e = 1'b1;
      for (int i = 0; i < c_N; i++) begin
         if (exp_q[i].size() != 0) e = 1'b0;
      end
      return e;
   endfunction

   // Handshakes are sampled mid-cycle; the word consumed is scored against its source queue
   always @(negedge clk) begin
      acc_pend = '0;
      if (reset) begin
         for (int i = 0; i < c_N; i++) wait_cnt[i] = 0;
      end else begin
         acc_pend = tb_in_valid & ob_in_ready;
         if (ob_out_valid && tb_out_ready) begin
            tr_src.push_back(int'(ob_out_src));
            tr_data.push_back(ob_out_data);
            tr_cyc.push_back(cyc);
            check_val("sb_avail", 32'(exp_q[ob_out_src].size() > 0), 32'd1);
            if (exp_q[ob_out_src].size() > 0) begin
               check_val("sb_data", 32'(ob_out_data), 32'(exp_q[ob_out_src].pop_front()));
            end
         end
         for (int i = 0; i < c_N; i++) begin
            if (!tb_in_valid[i] || acc_pend[i]) wait_cnt[i] = 0;
            else if (tb_out_ready) wait_cnt[i] = wait_cnt[i] + 1;
            if (wait_en && (wait_cnt[i] > max_wait)) max_wait = wait_cnt[i];
         end
      end
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      for (int i = 0; i < c_N; i++) begin
         if (acc_pend[i] && (src_q[i].size() > 0)) void'(src_q[i].pop_front());
         if (gate_rand) gate[i] = ($urandom_range(0, 3) != 0);
      end
      rdy_roll = ($urandom_range(0, 3) != 0);
      drive_inputs();
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic push(input int s, input logic [c_DW-1:0] w);
      src_q[s].push_back(w);
      exp_q[s].push_back(w);
      drive_inputs();
   endtask

   task automatic clear_all();
      for (int i = 0; i < c_N; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
      tr_src.delete();
      tr_cyc.delete();
      tr_data.delete();
      drive_inputs();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      clear_all();
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (!all_empty() && (n < budget)) begin
         tick(1);
         n++;
      end
      check_val(tag, 32'(all_empty()), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      logic [c_DW-1:0] ev [5];
      int eo [5];
      int es [5];

      drive_inputs();
      tick(3);
      reset = 1'b0;
      check_val("rst_valid4", 32'(bus4.out_valid), 32'd0);
      check_val("rst_data4",  32'(bus4.out_data),  32'd0);
      check_val("rst_src4",   32'(bus4.out_src),   32'd0);
      check_val("rst_ready4", 32'(bus4.in_ready),  32'd0);
      check_val("rst_valid2", 32'(bus2.out_valid), 32'd0);
      check_val("rst_ready2", 32'(bus2.in_ready),  32'd0);
      tick(1);

      // Single requester, BURST=4
      sel = 1'b0;
      apply_reset();
      rdy_force = 1'b1;
      c0 = cyc;
      ev[0] = c_DW'(5);
      ev[1] = c_DW'(-3);
      ev[2] = c_DW'(999);
      for (int k = 0; k < 3; k++) push(2, ev[k]);
      drain("single_drain", 30);
      check_val("single_count", 32'(tr_src.size()), 32'd3);
      for (int k = 0; (k < 3) && (k < tr_src.size()); k++) begin
         check_val("single_src",  32'(tr_src[k]),  32'd2);
         check_val("single_data", 32'(tr_data[k]), 32'(ev[k]));
         check_val("single_cyc",  32'(tr_cyc[k]),  32'(c0 + 2 + k));
      end

      // Round robin, BURST=2
      sel = 1'b1;
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         for (int s = 0; s < c_N; s++) push(s, c_DW'(100 * s + k));
      end
      drain("rr_drain", 80);
      check_val("rr_count", 32'(tr_src.size()), 32'd20);
      for (int k = 0; (k < 10) && (k < tr_src.size()); k++) begin
         check_val("rr_src", 32'(tr_src[k]), 32'((k / 2) % c_N));
         if (k > 0) check_val("rr_gap", 32'(tr_cyc[k] - tr_cyc[k-1]), (k % 2 == 0) ? 32'd2 : 32'd1);
      end

      // Backpressure on requester 1
      sel = 1'b0;
      apply_reset();
      rdy_force = 1'b1;
      c0 = cyc;
      push(1, c_DW'(7));
      push(1, c_DW'(8));
      push(1, c_DW'(9));
      tick(1);
      rdy_force = 1'b0;
      drive_inputs();
      for (int k = 0; k < 5; k++) begin
         tick(1);
         check_val("bp_valid", 32'(ob_out_valid),   32'd1);
         check_val("bp_data",  32'(ob_out_data),    32'd7);
         check_val("bp_ready", 32'(ob_in_ready[1]), 32'd0);
      end
      tick(1);
      rdy_force = 1'b1;
      drive_inputs();
      drain("bp_drain", 30);
      check_val("bp_count", 32'(tr_data.size()), 32'd3);
      for (int k = 0; (k < 3) && (k < tr_data.size()); k++) begin
         check_val("bp_order", 32'(tr_data[k]), 32'(7 + k));
         check_val("bp_cyc",   32'(tr_cyc[k]),  32'(c0 + 7 + k));
      end

      // Early release of requester 0, requester 3 waiting
      apply_reset();
      c0 = cyc;
      push(0, c_DW'(11));
      push(3, c_DW'(31));
      push(3, c_DW'(32));
      push(3, c_DW'(33));
      tick(3);
      push(0, c_DW'(12));
      drain("er_drain", 40);
      es = '{0, 3, 3, 3, 0};
      eo = '{2, 5, 6, 7, 10};
      ev[0] = c_DW'(11); ev[1] = c_DW'(31); ev[2] = c_DW'(32); ev[3] = c_DW'(33); ev[4] = c_DW'(12);
      check_val("er_count", 32'(tr_src.size()), 32'd5);
      for (int k = 0; (k < 5) && (k < tr_src.size()); k++) begin
         check_val("er_src",  32'(tr_src[k]),  32'(es[k]));
         check_val("er_data", 32'(tr_data[k]), 32'(ev[k]));
         check_val("er_cyc",  32'(tr_cyc[k]),  32'(c0 + eo[k]));
      end

      // Reset while a stalled word is held and requester 2 is granted
      apply_reset();
      rdy_force = 1'b0;
      drive_inputs();
      push(2, c_DW'(21));
      push(2, c_DW'(22));
      tick(2);
      check_val("mr_pre_valid", 32'(ob_out_valid), 32'd1);
      for (int s = 0; s < c_N; s++) push(s, c_DW'(40 + s));
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check_val("mr_valid", 32'(ob_out_valid), 32'd0);
      check_val("mr_ready", 32'(ob_in_ready),  32'd0);
      clear_all();
      for (int s = 0; s < c_N; s++) push(s, c_DW'(50 + s));
      rdy_force = 1'b1;
      c0 = cyc;
      drive_inputs();
      drain("mr_drain", 40);
      check_val("mr_count", 32'(tr_src.size()), 32'd4);
      if (tr_src.size() > 0) begin
         check_val("mr_first_src", 32'(tr_src[0]), 32'd0);
         check_val("mr_first_cyc", 32'(tr_cyc[0]), 32'(c0 + 2));
      end

      // Random soak, BURST=4
      apply_reset();
      max_wait  = 0;
      wait_en   = 1'b1;
      rdy_rand  = 1'b1;
      gate_rand = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         int s;
         tick(1);
         s = $urandom_range(0, c_N - 1);
         if (($urandom_range(0, 1) != 0) && (src_q[s].size() < 4)) push(s, c_DW'($urandom));
      end
      gate_rand = 1'b0;
      gate      = '1;
      rdy_rand  = 1'b0;
      rdy_force = 1'b1;
      drive_inputs();
      drain("soak_drain", 300);
      wait_en = 1'b0;
      check_val("soak_fair", 32'(max_wait <= c_MAX_WAIT), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
